g2_hist_accum: RTL and testbench
================================

Name: g2_hist_accum

Overview:
- Histogram accumulation stage that sits directly upstream of the counter block RAM in the g2 datapath.
- Consumes a stream of delay-bin indices and performs a read-modify-write increment of the addressed counter.
- After reset it sweeps the memory to zero, and on request streams every counter out in address order with read-and-clear.
- Contains its own 1-cycle registered-read dual-port memory of depth 2^ADDR_W.

Parameters:
ADDR_W, 10, bin index width; memory depth = 2^ADDR_W
CNT_W, 18, counter width

Ports:
clk  in  1  clock
RST  in  1  reset, synchronous, active-low
in_valid  in  1  bin index valid
in_bin  in  ADDR_W  delay-bin index to increment
in_ready  out  1  block accepts in_bin this cycle
dump_req  in  1  one-cycle pulse: start readout
out_valid  out  1  readout word valid
out_ready  in  1  downstream accepts readout word
out_addr  out  ADDR_W  bin index of readout word
out_data  out  CNT_W  counter value of readout word
dump_done  out  1  one-cycle pulse after the last word is accepted
busy  out  1  high in any state other than ACCUM with an empty pipeline
ovf  out  1  sticky: a counter hit all-ones; cleared only by RST

Behaviour:
- Reset: clk and RST (synchronous, active-low). While RST=0, all outputs are 0 except busy=1.
- On RST release the block enters CLEAR. Registers reset to: state=CLEAR, clr_addr=0, pipeline valids=0, ovf=0.
- States: CLEAR, ACCUM, DRAIN, DUMP_RD, DUMP_OUT.
- CLEAR:
  - Writes 0 to address clr_addr each cycle, then increments clr_addr.
  - After writing address 2^ADDR_W-1, goes to ACCUM. Takes exactly 2^ADDR_W cycles.
  - in_ready=0 and busy=1 throughout.
- ACCUM: in_ready=1 unless dump_req is seen. Accepted beat = in_valid & in_ready.
  - Edge E0: in_bin is applied to the read port. p1_addr<=in_bin, p1_valid<=1.
  - Between E0 and E1: operand = fwd_hit ? wr_data_q : rd, where fwd_hit = wr_valid_q & (wr_addr_q==p1_addr). sum = operand+1 (saturating; see Optional Feature).
  - Edge E1: mem[p1_addr]<=sum. wr_addr_q<=p1_addr, wr_data_q<=sum, wr_valid_q<=p1_valid.
  - Sustained throughput is 1 bin/cycle. Back-to-back identical bins must each count, e.g. 3 consecutive bin 5 gives +3.
  - Memory read-during-write returns old data; the forwarding path covers this case.
  - A value is visible at the read port 2 cycles after acceptance.
- dump_req in ACCUM: in_ready drops the same cycle, and a beat presented that cycle is NOT accepted. Goes to DRAIN for 2 cycles to retire in-flight writes, then DUMP_RD with d_addr=0. dump_req in any other state is ignored.
- DUMP_RD: issues a read of d_addr, then goes to DUMP_OUT.
- DUMP_OUT:
  - out_valid=1, out_addr=d_addr, out_data=the registered read value. Held stable while out_ready=0.
  - On out_ready: mem[d_addr]<=0 (read-and-clear).
  - If d_addr==2^ADDR_W-1: pulse dump_done and return to ACCUM. Otherwise d_addr+1 and back to DUMP_RD.
  - Minimum 2 cycles per word.
- RST=0 mid-dump or mid-clear aborts immediately and restarts CLEAR on release. Memory contents are not guaranteed until CLEAR completes.
- Width rules: addresses wrap modulo 2^ADDR_W. Counters are CNT_W unsigned.

Optional Feature:
- Macro G2_HIST_SAT_EN.
- Defined: an increment of an all-ones counter leaves it at all-ones and sets ovf.
- Undefined: the counter wraps to 0 and also sets ovf.
- Forwarded operands obey the same rule.

Test Plan:
- Reset/clear: hold RST=0 for 3 cycles, release -> busy=1 and in_ready=0 for exactly 2^ADDR_W cycles. Immediate dump reads all zeros.
- Hazard: ADDR_W=4. Feed bins 5,5,5,7,5 back-to-back, then dump -> bin5=4, bin7=1, all other bins 0, dump_done once after addr 15.
- Backpressure: during dump, hold out_ready=0 for 5 cycles at addr 3 -> out_addr=3 and out_data stable; no skip or duplicate. A second dump returns all zeros (read-and-clear).
- Dump collision: assert dump_req in the same cycle as in_valid with bin 2 -> beat not accepted, bin2=0. The bin 9 beat before it is counted as 1.
- Saturation: CNT_W=4, 17 hits on bin 0 -> with G2_HIST_SAT_EN, bin0=15 and ovf=1. Without it, bin0=1 and ovf=1.
- Reset mid-dump: RST=0 at addr 6 -> out_valid=0 the next cycle, no dump_done, full CLEAR sweep runs again.

Source files
------------

// File: rtl/g2_hist_accum.sv
// g2_hist_accum: histogram accumulation stage ahead of the counter RAM.
//
// Takes a stream of delay-bin indices and increments the addressed counter
// with a read-modify-write through an internal dual-port memory (one write
// port, one registered read port, read-during-write returns old data).
// After reset the memory is swept to zero. A dump request streams every
// counter out in address order, clearing each one as it is accepted.
//
// Optional build macro: G2_HIST_SAT_EN
//   defined   - incrementing an all-ones counter holds it at all-ones
//   undefined - incrementing an all-ones counter wraps it to zero
//   In both cases the sticky ovf flag is set.
//
// Ports:
//   clk        clock
//   RST        synchronous active-low reset
//   in_valid   bin index valid
//   in_bin     bin index to increment
//   in_ready   bin accepted this cycle (drops with dump_req in the same cycle)
//   dump_req   one-cycle pulse, starts a readout (honoured only in ACCUM)
//   out_valid  readout word valid
//   out_ready  downstream accepts the readout word
//   out_addr   bin index of the readout word
//   out_data   counter value of the readout word
//   dump_done  one-cycle pulse after the last word is accepted
//   busy       high unless idle in ACCUM with no write pending
//   ovf        sticky: some counter was incremented from all-ones
module g2_hist_accum #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 18
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_bin,
    output logic              in_ready,
    input  logic              dump_req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]  out_data,
    output logic              dump_done,
    output logic              busy,
    output logic              ovf
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_DUMP_RD,
        S_DUMP_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [ADDR_W-1:0] d_addr_q, d_addr_d;
    logic              drain_q, drain_d;
    logic              dump_done_q, dump_done_d;

    // Increment pipeline: stage 1 waits for the read, write stage feeds forward.
    logic              p1_valid_q;
    logic [ADDR_W-1:0] p1_addr_q;
    logic              wr_valid_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [CNT_W-1:0]  wr_data_q;
    logic              ovf_q;

    // Memory and its registered read data.
    logic [CNT_W-1:0]  mem_q [DEPTH];
    logic [CNT_W-1:0]  rd_data_q;

    logic              accept_c;
    logic              fwd_hit_c;
    logic [CNT_W-1:0]  operand_c;
    logic              at_max_c;
    logic [CNT_W-1:0]  sum_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_wa_c;
    logic [CNT_W-1:0]  mem_wd_c;
    logic              rd_en_c;
    logic [ADDR_W-1:0] rd_addr_c;

    // Handshake: a dump request wins over a beat presented in the same cycle.
    assign in_ready = RST & (state_q == S_ACCUM) & ~dump_req;
    assign accept_c = in_valid & in_ready;

    // The previous write has not reached the read data yet; take it from the write stage.
    assign fwd_hit_c = wr_valid_q & (wr_addr_q == p1_addr_q);
    assign operand_c = fwd_hit_c ? wr_data_q : rd_data_q;
    assign at_max_c  = &operand_c;

`ifdef G2_HIST_SAT_EN
    assign sum_c = at_max_c ? operand_c : operand_c + CNT_W'(1);
`else
    assign sum_c = operand_c + CNT_W'(1);
`endif

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        d_addr_d    = d_addr_q;
        drain_d     = drain_q;
        dump_done_d = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == ADDR_MAX) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (dump_req) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                // Two cycles let the last accepted beat retire before readout.
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d  = S_DUMP_RD;
                    d_addr_d = '0;
                end
            end
            S_DUMP_RD: begin
                state_d = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (out_ready) begin
                    if (d_addr_q == ADDR_MAX) begin
                        state_d     = S_ACCUM;
                        dump_done_d = 1'b1;
                    end else begin
                        d_addr_d = d_addr_q + ADDR_W'(1);
                        state_d  = S_DUMP_RD;
                    end
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // Memory port control: clear sweep, read-and-clear, or increment writeback.
    always_comb begin
        mem_we_c = 1'b0;
        mem_wa_c = p1_addr_q;
        mem_wd_c = sum_c;
        if (RST) begin
            if (state_q == S_CLEAR) begin
                mem_we_c = 1'b1;
                mem_wa_c = clr_addr_q;
                mem_wd_c = '0;
            end else if ((state_q == S_DUMP_OUT) && out_ready) begin
                mem_we_c = 1'b1;
                mem_wa_c = d_addr_q;
                mem_wd_c = '0;
            end else if (p1_valid_q) begin
                mem_we_c = 1'b1;
            end
        end
        // Read data is held while a dump word waits on out_ready.
        rd_en_c   = accept_c | (RST & (state_q == S_DUMP_RD));
        rd_addr_c = (state_q == S_DUMP_RD) ? d_addr_q : in_bin;
    end

    // Control and pipeline registers.
    always_ff @(posedge clk) begin
        if (!RST) begin
            state_q     <= S_CLEAR;
            clr_addr_q  <= '0;
            d_addr_q    <= '0;
            drain_q     <= 1'b0;
            dump_done_q <= 1'b0;
            p1_valid_q  <= 1'b0;
            p1_addr_q   <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            d_addr_q    <= d_addr_d;
            drain_q     <= drain_d;
            dump_done_q <= dump_done_d;
            p1_valid_q  <= accept_c;
            if (accept_c) begin
                p1_addr_q <= in_bin;
            end
            wr_valid_q  <= p1_valid_q;
            wr_addr_q   <= p1_addr_q;
            wr_data_q   <= sum_c;
            if (p1_valid_q && at_max_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Counter memory: one write port, one registered read port (old data on collision).
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_wa_c] <= mem_wd_c;
        end
        if (rd_en_c) begin
            rd_data_q <= mem_q[rd_addr_c];
        end
    end

    // Outputs are forced to their reset values while RST is low.
    assign out_valid = RST & (state_q == S_DUMP_OUT);
    assign out_addr  = out_valid ? d_addr_q : '0;
    assign out_data  = out_valid ? rd_data_q : '0;
    assign dump_done = RST & dump_done_q;
    assign busy      = ~RST | (state_q != S_ACCUM) | p1_valid_q;
    assign ovf       = RST & ovf_q;

endmodule

// File: tb/tb_g2_hist_accum.sv
module tb_g2_hist_accum;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int DEPTH = 16;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [ADDR_W-1:0] in_bin;
    logic              in_ready;
    logic              dump_req;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [CNT_W-1:0]  out_data;
    logic              dump_done;
    logic              busy;
    logic              ovf;

    int n_cmp;
    int n_err;
    int dump_val [DEPTH];
    int exp_val  [DEPTH];
    int done_cnt;

    g2_hist_accum #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .RST      (rst),
        .in_valid (in_valid),
        .in_bin   (in_bin),
        .in_ready (in_ready),
        .dump_req (dump_req),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
        .out_data (out_data),
        .dump_done(dump_done),
        .busy     (busy),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp;
        for (int i = 0; i < DEPTH; i++) exp_val[i] = 0;
    endtask

    // Release reset and measure the busy/in_ready window of the clear sweep.
    task automatic release_and_clear(input string tag);
        int cnt;
        bit bad;
        cnt = 0;
        bad = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (busy !== 1'b1) break;
            if (in_ready !== 1'b0) bad = 1'b1;
            cnt++;
            step;
        end
        n_cmp++;
        if (cnt != DEPTH) begin
            n_err++;
            $display("FAIL %s_clear_len: busy cycles %0d, want %0d", tag, cnt, DEPTH);
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL %s_clear_in_ready: in_ready went high during clear, want 0", tag);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_accum_ready: in_ready %b, want 1", tag, in_ready);
        end
    endtask

    task automatic send_bin(input int b);
        in_valid = 1'b1;
        in_bin   = 4'(b);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL send_ready bin %0d: in_ready %b, want 1", b, in_ready);
        end
        step;
        in_valid = 1'b0;
    endtask

    // Collects one full readout into dump_val, optionally stalling at one address.
    task automatic do_dump(input bit issue, input int stall_addr, input int stall_n);
        int  exp_a;
        int  post;
        bit  stalled;
        exp_a    = 0;
        post     = 0;
        stalled  = 1'b0;
        done_cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) dump_val[i] = -1;
        if (issue) begin
            dump_req = 1'b1;
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL dump_req_in_ready: in_ready %b, want 0", in_ready);
            end
            step;
            dump_req = 1'b0;
        end
        for (int cyc = 0; cyc < 200 && post < 3; cyc++) begin
            if (dump_done === 1'b1) begin
                done_cnt++;
                n_cmp++;
                if (exp_a != DEPTH) begin
                    n_err++;
                    $display("FAIL dump_done_early: words seen %0d, want %0d", exp_a, DEPTH);
                end
            end
            if (exp_a == DEPTH) begin
                post++;
            end else if (out_valid === 1'b1) begin
                n_cmp++;
                if (out_addr !== 4'(exp_a)) begin
                    n_err++;
                    $display("FAIL dump_addr: out_addr %0d, want %0d", out_addr, exp_a);
                end
                dump_val[exp_a] = int'(out_data);
                if (!stalled && exp_a == stall_addr && stall_n > 0) begin
                    stalled   = 1'b1;
                    out_ready = 1'b0;
                    repeat (stall_n) begin
                        step;
                        n_cmp++;
                        if (out_valid !== 1'b1 || out_addr !== 4'(exp_a) ||
                            int'(out_data) != dump_val[exp_a]) begin
                            n_err++;
                            $display("FAIL stall_hold: valid %b addr %0d data %0d, want 1 %0d %0d",
                                     out_valid, out_addr, out_data, exp_a, dump_val[exp_a]);
                        end
                    end
                    out_ready = 1'b1;
                end
                exp_a++;
            end
            step;
        end
        n_cmp++;
        if (exp_a != DEPTH) begin
            n_err++;
            $display("FAIL dump_timeout: words %0d, want %0d", exp_a, DEPTH);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) begin
            step;
            n_cmp++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
                dump_done !== 1'b0 || ovf !== 1'b0) begin
                n_err++;
                $display("FAIL reset_outputs: busy %b rdy %b ov %b dd %b ovf %b, want 1 0 0 0 0",
                         busy, in_ready, out_valid, dump_done, ovf);
            end
        end
        release_and_clear("reset");
        clear_exp();
        do_dump(1'b1, -1, 0);
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (dump_val[i] != exp_val[i]) begin
                n_err++;
                $display("FAIL reset_dump bin %0d: got %0d, want %0d", i, dump_val[i], exp_val[i]);
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL reset_done_count: %0d, want 1", done_cnt);
        end
    endtask

    task automatic test_hazard;
        send_bin(5); send_bin(5); send_bin(5); send_bin(7); send_bin(5);
        repeat (3) step;
        clear_exp();
        exp_val[5] = 4;
        exp_val[7] = 1;
        do_dump(1'b1, -1, 0);
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (dump_val[i] != exp_val[i]) begin
                n_err++;
                $display("FAIL hazard bin %0d: got %0d, want %0d", i, dump_val[i], exp_val[i]);
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL hazard_done_count: %0d, want 1", done_cnt);
        end
    endtask

    task automatic test_backpressure;
        send_bin(3); send_bin(1); send_bin(3); send_bin(4);
        repeat (2) step;
        clear_exp();
        exp_val[3] = 2;
        exp_val[1] = 1;
        exp_val[4] = 1;
        do_dump(1'b1, 3, 5);
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (dump_val[i] != exp_val[i]) begin
                n_err++;
                $display("FAIL bp bin %0d: got %0d, want %0d", i, dump_val[i], exp_val[i]);
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL bp_done_count: %0d, want 1", done_cnt);
        end
        step;
        clear_exp();
        do_dump(1'b1, -1, 0);
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (dump_val[i] != 0) begin
                n_err++;
                $display("FAIL read_clear bin %0d: got %0d, want 0", i, dump_val[i]);
            end
        end
    endtask

    task automatic test_dump_collision;
        send_bin(9);
        in_valid = 1'b1;
        in_bin   = 4'd2;
        dump_req = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL collision_ready: in_ready %b, want 0", in_ready);
        end
        step;
        in_valid = 1'b0;
        dump_req = 1'b0;
        clear_exp();
        exp_val[9] = 1;
        do_dump(1'b0, -1, 0);
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (dump_val[i] != exp_val[i]) begin
                n_err++;
                $display("FAIL collision bin %0d: got %0d, want %0d", i, dump_val[i], exp_val[i]);
            end
        end
    endtask

    task automatic test_saturation;
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_before: ovf %b, want 0", ovf);
        end
        repeat (17) send_bin(0);
        repeat (3) step;
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_after: ovf %b, want 1", ovf);
        end
        clear_exp();
`ifdef G2_HIST_SAT_EN
        exp_val[0] = 15;
`else
        exp_val[0] = 1;
`endif
        do_dump(1'b1, -1, 0);
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (dump_val[i] != exp_val[i]) begin
                n_err++;
                $display("FAIL sat bin %0d: got %0d, want %0d", i, dump_val[i], exp_val[i]);
            end
        end
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: ovf %b, want 1", ovf);
        end
    endtask

    task automatic test_reset_mid_dump;
        bit found;
        bit dd_seen;
        found   = 1'b0;
        dd_seen = 1'b0;
        send_bin(6);
        repeat (2) step;
        out_ready = 1'b1;
        dump_req  = 1'b1;
        step;
        dump_req  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid === 1'b1 && out_addr === 4'd6) begin
                found = 1'b1;
                break;
            end
            step;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL middump_reach: addr 6 not reached, want reached");
        end
        rst = 1'b0;
        step;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL middump_abort: out_valid %b busy %b, want 0 1", out_valid, busy);
        end
        repeat (2) begin
            if (dump_done !== 1'b0) dd_seen = 1'b1;
            step;
        end
        release_and_clear("middump");
        n_cmp++;
        if (dd_seen) begin
            n_err++;
            $display("FAIL middump_done: dump_done seen, want none");
        end
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL middump_ovf: ovf %b, want 0", ovf);
        end
        do_dump(1'b1, -1, 0);
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (dump_val[i] != 0) begin
                n_err++;
                $display("FAIL middump_zero bin %0d: got %0d, want 0", i, dump_val[i]);
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL middump_done_count: %0d, want 1", done_cnt);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_bin    = '0;
        dump_req  = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_hazard();
        test_backpressure();
        test_dump_collision();
        test_saturation();
        test_reset_mid_dump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
